// File: rtl/alu_serial_ctrl_if.sv
// Request/response bundle between a requester and the bit-serial ALU sequencer.
interface alu_serial_ctrl_if #(parameter int WIDTH = 32);
  logic             start;
  logic [2:0]       op;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] result;
  logic             zero;
  logic             overflow;
  logic             cout;

  modport master (output start, op, a, b,
                  input  busy, done, result, zero, overflow, cout);
  modport slave  (input  start, op, a, b,
                  output busy, done, result, zero, overflow, cout);
endinterface

// File: rtl/alu_serial_ctrl.sv
// Bit-serial sequencer for a 1-bit ALU slice: LSB-first, carry kept in a flop,
// SLT resolved by a fix-up cycle that moves the MSB sum bit into bit 0.
module alu_serial_ctrl #(
  parameter int WIDTH = 32
) (
  input  logic               clk,
  input  logic               rst,
  alu_serial_ctrl_if.slave   bus,
  output logic               slice_a,
  output logic               slice_b,
  output logic               slice_cin,
  output logic               slice_less,
  output logic [2:0]         slice_op,
  input  logic               slice_result,
  input  logic               slice_cout,
  input  logic               slice_set
);
  localparam int KW = $clog2(WIDTH);
  localparam logic [KW-1:0] K_LAST = KW'(WIDTH - 1);

  typedef enum logic [1:0] {IDLE, RUN, FIX, DONE} state_t;

  state_t           state;
  logic [WIDTH-1:0] a_q, b_q, res_q;
  logic [2:0]       op_q;
  logic [KW-1:0]    k;
  logic             carry, sign, c_in_msb, c_out;
  logic             busy_q, done_q, zero_q, ovf_q, cout_q;

  assign slice_a    = a_q[k];
  assign slice_b    = b_q[k];
  assign slice_cin  = carry;
  assign slice_less = 1'b0;
  assign slice_op   = op_q;

  assign bus.busy     = busy_q;
  assign bus.done     = done_q;
  assign bus.result   = res_q;
  assign bus.zero     = zero_q;
  assign bus.overflow = ovf_q;
  assign bus.cout     = cout_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      a_q      <= '0;
      b_q      <= '0;
      op_q     <= '0;
      k        <= '0;
      carry    <= 1'b0;
      sign     <= 1'b0;
      c_in_msb <= 1'b0;
      c_out    <= 1'b0;
      res_q    <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      zero_q   <= 1'b0;
      ovf_q    <= 1'b0;
      cout_q   <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state)
        IDLE: if (bus.start) begin
          a_q    <= bus.a;
          b_q    <= bus.b;
          op_q   <= bus.op;
          k      <= '0;
          carry  <= bus.op[2];
          res_q  <= '0;
          zero_q <= 1'b0;
          ovf_q  <= 1'b0;
          cout_q <= 1'b0;
          busy_q <= 1'b1;
          state  <= RUN;
        end
        RUN: begin
          res_q[k] <= slice_result;
          carry    <= slice_cout;
          if (k == K_LAST) begin
            // MSB carry-in/out pair drives the signed overflow flag
            sign     <= slice_set;
            c_in_msb <= carry;
            c_out    <= slice_cout;
            if (op_q[1:0] == 2'b11) begin
              state <= FIX;
            end else begin
              busy_q <= 1'b0;
              state  <= DONE;
            end
          end else begin
            k <= k + 1'b1;
          end
        end
        FIX: begin
          res_q  <= {{(WIDTH-1){1'b0}}, sign};
          busy_q <= 1'b0;
          state  <= DONE;
        end
        DONE: begin
          done_q <= 1'b1;
          zero_q <= ~|res_q;
          ovf_q  <= op_q[1] & (c_in_msb ^ c_out);
          cout_q <= op_q[1] & c_out;
          state  <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule
